// File: rtl/MCPkg.sv
// Shared definitions for the extremity switch logic.
// Holds the per-side switch configuration word layout and its field positions.
package MCPkg;

  // Bit positions of the configuration fields inside a switchstate_t word.
  localparam int SW_SRC_BIT = 0;
  localparam int SW_INV_BIT = 1;
  localparam int SW_EN_BIT  = 2;

  // Per-side configuration word.
  // reserved bits carry no function, but any change to them still counts as a config rewrite.
  typedef struct packed {
    logic [12:0] reserved;
    logic        enable;
    logic        invert;
    logic        src;
  } switchstate_t;

endpackage

// File: rtl/extremity_switch_mapper_get_edge.sv
// Edge detector: registers a level and flags its rising and falling transitions.
// The edge flags are combinational against the registered copy, so they are
// valid during the cycle before data_o takes the new level.
module get_edge (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic data_i,
  output logic data_o,
  output logic rising_o,
  output logic falling_o
);

  // One-cycle registered copy of the input level; cleared by reset.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      data_o <= 1'b0;
    end else begin
      data_o <= data_i;
    end
  end

  // Transition flags compare the live input against the stored level.
  always_comb begin
    rising_o  = data_i & ~data_o;
    falling_o = ~data_i & data_o;
  end

endmodule

// File: rtl/extremity_switch_mapper.sv
// Maps two debounced extremity contacts onto a green/red LED pair per side.
// Path: contact -> hit term (comb) -> get_edge register -> LED decode -> LED register,
// giving two cycles from rawswitches and one cycle from blinker_i to the LEDs.
// Index 0 is the left extremity, index 1 the right extremity.
module extremity_switch_mapper
  import MCPkg::*;
(
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic [1:0]         rawswitches,
  input  switchstate_t [1:0] switchesconfig,
  input  logic               blinker_i,
  output logic               led_lg,
  output logic               led_lr,
  output logic               led_rg,
  output logic               led_rr
);

  logic [1:0]         hit_term;         // live shall-hit term per side
  logic [1:0]         hit_state;        // registered hit level per side
  logic [1:0]         hit_rise;         // hit event per side
  logic [1:0]         hit_fall_unused;  // release events are not needed here
  logic [1:0]         hit_seen_q;       // sticky "was hit since last config rewrite"
  switchstate_t [1:0] cfg_q;            // config words from the previous cycle
  logic [1:0]         cfg_changed;
  logic [1:0]         green_d;
  logic [1:0]         red_d;
  logic               fault;

  // Shall-hit term: selected contact, optionally inverted for NC contacts, gated by enable.
  always_comb begin
    hit_term = 2'b00;
    for (int s = 0; s < 2; s++) begin
      hit_term[s] = switchesconfig[s].enable &
                    (rawswitches[switchesconfig[s].src] ^ switchesconfig[s].invert);
    end
  end

  get_edge u_edge_left (
    .clk_i     (clk_i),
    .reset_ni  (reset_ni),
    .data_i    (hit_term[0]),
    .data_o    (hit_state[0]),
    .rising_o  (hit_rise[0]),
    .falling_o (hit_fall_unused[0])
  );

  get_edge u_edge_right (
    .clk_i     (clk_i),
    .reset_ni  (reset_ni),
    .data_i    (hit_term[1]),
    .data_o    (hit_state[1]),
    .rising_o  (hit_rise[1]),
    .falling_o (hit_fall_unused[1])
  );

  // Remember each side's config word so a rewrite (any bit, reserved included) can be seen.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      cfg_q <= '0;
    end else begin
      cfg_q <= switchesconfig;
    end
  end

  // A config word differing from last cycle's copy is a rewrite.
  always_comb begin
    cfg_changed = 2'b00;
    for (int s = 0; s < 2; s++) begin
      cfg_changed[s] = (switchesconfig[s] != cfg_q[s]);
    end
  end

  // Sticky hit-seen flags: set by a hit event, cleared by a config rewrite (clear wins).
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      hit_seen_q <= 2'b00;
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (cfg_changed[s]) begin
          hit_seen_q[s] <= 1'b0;
        end else if (hit_rise[s]) begin
          hit_seen_q[s] <= 1'b1;
        end
      end
    end
  end

  // LED decode per side in priority order: disabled, fault, hit, seen, idle.
  always_comb begin
    green_d = 2'b00;
    red_d   = 2'b00;
    fault   = switchesconfig[0].enable & switchesconfig[1].enable &
              hit_state[0] & hit_state[1];
    for (int s = 0; s < 2; s++) begin
      if (!switchesconfig[s].enable) begin
        green_d[s] = 1'b0;
        red_d[s]   = 1'b0;
      end else if (fault) begin
        red_d[s]   = blinker_i;
      end else if (hit_state[s]) begin
        red_d[s]   = 1'b1;
      end else if (hit_seen_q[s]) begin
        green_d[s] = blinker_i;
      end else begin
        green_d[s] = 1'b1;
      end
    end
  end

  // Registered LED outputs; all dark while in reset.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      led_lg <= 1'b0;
      led_lr <= 1'b0;
      led_rg <= 1'b0;
      led_rr <= 1'b0;
    end else begin
      led_lg <= green_d[0];
      led_lr <= red_d[0];
      led_rg <= green_d[1];
      led_rr <= red_d[1];
    end
  end

endmodule

// File: tb/tb_extremity_switch_mapper.sv
// Bench for extremity_switch_mapper: directed scenarios followed by random traffic.
// Every cycle's inputs are logged; expected LEDs are derived from that history.
module tb_extremity_switch_mapper;
  import MCPkg::*;

  localparam int MAXC = 2200;

  // ---------------- clock / reset / DUT ----------------
  logic               clk_i = 1'b0;
  logic               reset_ni;
  logic [1:0]         rawswitches;
  switchstate_t [1:0] switchesconfig;
  logic               blinker_i;
  logic               led_lg, led_lr, led_rg, led_rr;

  always #5 clk_i = ~clk_i;

  extremity_switch_mapper dut (
    .clk_i          (clk_i),
    .reset_ni       (reset_ni),
    .rawswitches    (rawswitches),
    .switchesconfig (switchesconfig),
    .blinker_i      (blinker_i),
    .led_lg         (led_lg),
    .led_lr         (led_lr),
    .led_rg         (led_rg),
    .led_rr         (led_rr)
  );

  // ---------------- input history ----------------
  logic        rst_a   [MAXC];
  logic [1:0]  raw_a   [MAXC];
  logic [15:0] cfg_a   [2][MAXC];
  logic        blink_a [MAXC];
  int          cyc = 0;

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end else begin
      n_pass++;
    end
  endtask

  // ---------------- reference model over the history ----------------
  // Shall-hit term of side s for the inputs presented at edge m.
  function automatic logic hit_at(int s, int m);
    logic [15:0] c;
    c = cfg_a[s][m];
    return c[SW_EN_BIT] & (raw_a[m][c[SW_SRC_BIT]] ^ c[SW_INV_BIT]);
  endfunction

  // Registered hit level after edge m.
  function automatic logic state_after(int s, int m);
    if (m < 0) return 1'b0;
    if (rst_a[m]) return 1'b0;
    return hit_at(s, m);
  endfunction

  // Config word the block remembers going into edge m.
  function automatic logic [15:0] prev_cfg(int s, int m);
    if (m <= 0) return 16'h0;
    if (rst_a[m-1]) return 16'h0;
    return cfg_a[s][m-1];
  endfunction

  function automatic logic clear_at(int s, int m);
    return rst_a[m] || (cfg_a[s][m] != prev_cfg(s, m));
  endfunction

  function automatic logic rise_at(int s, int m);
    return hit_at(s, m) && !state_after(s, m - 1);
  endfunction

  // Hit-seen after edge t: the latest event is a hit event, and a clear beats a set at the same edge.
  function automatic logic seen_after(int s, int t);
    for (int j = t; j >= 0; j--) begin
      if (clear_at(s, j)) return 1'b0;
      if (rise_at(s, j)) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Expected {lg, lr, rg, rr} right after edge t.
  function automatic logic [3:0] expect_leds(int t);
    logic [1:0] en, hs, sn, g, r;
    logic       flt;
    if (rst_a[t]) return 4'b0000;
    for (int s = 0; s < 2; s++) begin
      en[s] = cfg_a[s][t][SW_EN_BIT];
      hs[s] = state_after(s, t - 1);
      sn[s] = seen_after(s, t - 1);
    end
    flt = &en && &hs;
    for (int s = 0; s < 2; s++) begin
      g[s] = 1'b0;
      r[s] = 1'b0;
      if (!en[s])     begin end
      else if (flt)   r[s] = blink_a[t];
      else if (hs[s]) r[s] = 1'b1;
      else if (sn[s]) g[s] = blink_a[t];
      else            g[s] = 1'b1;
    end
    return {g[0], r[0], g[1], r[1]};
  endfunction

  // ---------------- driver ----------------
  // Apply one cycle of inputs, clock it, then compare the LEDs with the model.
  task automatic step(input logic rn, input logic [1:0] raw, input logic [15:0] cl,
                      input logic [15:0] cr, input logic bl);
    if (cyc >= MAXC) begin
      $display("FAIL history_overflow: got %0d expected below %0d", cyc, MAXC);
      $fatal(1, "history overflow");
    end
    reset_ni          = rn;
    rawswitches       = raw;
    switchesconfig[0] = cl;
    switchesconfig[1] = cr;
    blinker_i         = bl;
    rst_a[cyc]        = !rn;
    raw_a[cyc]        = raw;
    cfg_a[0][cyc]     = cl;
    cfg_a[1][cyc]     = cr;
    blink_a[cyc]      = bl;
    @(posedge clk_i);
    #1;
    check_eq("leds", {led_lg, led_lr, led_rg, led_rr}, expect_leds(cyc));
    cyc++;
  endtask

  // Current drive values kept by the directed scenarios.
  logic        c_rn;
  logic [1:0]  c_raw;
  logic [15:0] c_cl, c_cr;
  logic        c_bl;

  task automatic go(input int n);
    for (int i = 0; i < n; i++) step(c_rn, c_raw, c_cl, c_cr, c_bl);
  endtask

  // ---------------- stimulus ----------------
  logic [15:0] cfg_pick;

  initial begin
    c_rn = 1'b0; c_raw = 2'b00; c_cl = 16'h0; c_cr = 16'h0; c_bl = 1'b0;
    go(2);
    check_eq("reset_leds", {led_lg, led_lr, led_rg, led_rr}, 4'b0000);
    c_rn = 1'b1;
    go(1);

    // Contact toggle on the left side.
    c_cl = 16'h0004;
    go(3);
    check_eq("idle_lg", led_lg, 1'b1);
    c_raw = 2'b01;
    go(1);
    check_eq("toggle_lr_cyc1", led_lr, 1'b0);
    go(1);
    check_eq("toggle_lr", led_lr, 1'b1);
    check_eq("toggle_lg", led_lg, 1'b0);

    // Release: green follows the blinker, then a same-field rewrite clears hit-seen.
    c_raw = 2'b00;
    for (int i = 0; i < 16; i++) begin
      if (i % 4 == 0) c_bl = ~c_bl;
      go(1);
    end
    c_bl = 1'b0;
    go(2);
    check_eq("seen_lg_blink_low", led_lg, 1'b0);
    c_bl = 1'b1;
    go(1);
    check_eq("seen_lg_blink_high", led_lg, 1'b1);
    c_cl = 16'h8004;
    c_bl = 1'b0;
    go(3);
    check_eq("rewrite_lg_steady", led_lg, 1'b1);
    check_eq("rewrite_lr", led_lr, 1'b0);

    // Inverted contact on the right side.
    c_cr = 16'h0007;
    go(2);
    check_eq("inv_rr", led_rr, 1'b1);
    check_eq("inv_rg", led_rg, 1'b0);

    // Fault: both sides hit.
    c_raw = 2'b01;
    c_bl  = 1'b1;
    go(3);
    check_eq("fault_hi", {led_lg, led_lr, led_rg, led_rr}, 4'b0101);
    c_bl = 1'b0;
    go(1);
    check_eq("fault_lo", {led_lg, led_lr, led_rg, led_rr}, 4'b0000);

    // Both sides on the same contact: still a fault.
    c_cr = 16'h0004;
    c_bl = 1'b1;
    go(3);
    check_eq("same_src_fault", {led_lg, led_lr, led_rg, led_rr}, 4'b0101);

    // Left disabled: dark regardless of contacts.
    c_cl = 16'h0000;
    for (int i = 0; i < 6; i++) begin
      c_raw = 2'($urandom_range(0, 3));
      go(1);
      check_eq("disabled_left", {led_lg, led_lr}, 2'b00);
    end

    // Reset during a hit, then re-detection two cycles after release.
    c_cl = 16'h0004; c_cr = 16'h0000; c_raw = 2'b01;
    go(3);
    check_eq("prereset_lr", led_lr, 1'b1);
    c_rn = 1'b0;
    go(1);
    check_eq("reset_mid_hit", {led_lg, led_lr, led_rg, led_rr}, 4'b0000);
    c_rn = 1'b1;
    go(1);
    check_eq("post_reset_cyc1", led_lr, 1'b0);
    go(1);
    check_eq("post_reset_red", led_lr, 1'b1);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      c_raw = 2'($urandom_range(0, 3));
      c_bl  = 1'($urandom_range(0, 1));
      c_rn  = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 15) == 0) begin
        cfg_pick = {($urandom_range(0, 3) == 0) ? 13'($urandom) : 13'h0, 3'($urandom_range(0, 7))};
        if ($urandom_range(0, 1) == 0) c_cl = cfg_pick;
        else                           c_cr = cfg_pick;
      end
      go(1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
